fpaddsub_c_32: RTL and testbench
================================

Name: fpaddsub_c_32

Overview:
Final stage of the single-precision add/sub datapath. It consumes the 16|0 pre-shifted sum, shift amount, result sign and effective operation produced by the add/LZD stage. It completes normalization (residual 0–15 bit shift), rounds to nearest-even, and packs an IEEE-754 binary32 result. It is a 2-stage valid/ready pipeline with backpressure, so it can sit between the combinational add stage and a stallable writeback.

Parameters:
EXP_W, 8, exponent width; the datapath is verified only at 8.
FRAC_W, 23, stored fraction width; the sum width is FRAC_W+10 (33).
BIAS, 127, exponent bias; used only for range checks.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
SumS_5  in  33  sum after the 16|0 shift
Shift  in  5  total normalization shift (0..26)
Emax  in  8  biased exponent of the larger operand
PSgn  in  1  result sign
Opr  in  1  effective operation (1 = subtract)
out_valid  out  1  result valid
out_ready  in  1  downstream accepts the result
Result  out  32  packed binary32 result
Ovf  out  1  result overflowed to infinity
Unf  out  1  result underflowed and was flushed to zero

Behaviour:
- Reset (asynchronous, rst_n low): both stage valid bits clear; out_valid=0; Result=0; Ovf=0; Unf=0. in_ready=1 once rst_n is high.
- Pipeline handshake:
  - s2_en = !s2_valid | out_ready; s1_en = !s1_valid | s2_en; in_ready = s1_en (combinational from out_ready).
  - A beat transfers on in_valid & in_ready; the result appears with out_valid high 2 cycles later when there is no stall.
  - The output is held stable while out_valid & !out_ready.
  - Sustained throughput is 1 beat/cycle. No beats are dropped or duplicated under any out_ready pattern.
- Stage 1 (normalize):
  - N = SumS_5 << Shift[3:0], using barrel levels 8/4/2/1.
  - E1 = {0,Emax} + 1 − Shift, computed as a 10-bit signed value.
  - Z = (Shift == 26) or (SumS_5 == 0).
  - Register N, E1, Z, PSgn and Opr.
- Stage 2 (round and pack):
  - Fields: frac = N[31:9]; L = N[9]; G = N[8]; R = N[7]; S = |N[6:0].
  - Increment inc = G & (R | S | L).
  - {c, f} = frac + inc. If c=1, then f = 0 and E2 = E1 + 1; otherwise E2 = E1.
  - Exact zero (Z): Result = {Opr ? 1'b0 : PSgn, 31'b0}, Ovf=0, Unf=0.
  - Overflow (E2 ≥ 255): Result = {PSgn, 8'hFF, 23'b0}, Ovf=1.
  - Underflow (E2 ≤ 0): Result = {PSgn, 31'b0}, Unf=1. Denormals are flushed, never produced.
  - Otherwise: Result = {PSgn, E2[7:0], f}.
- Input assumptions and required handling:
  - Shift values 27–31 never occur at the input; the block treats them as zero.
  - Emax == 255 (NaN/Inf operand) is handled upstream; the block still produces the overflow encoding deterministically.
- Reset asserted mid-operation discards all in-flight beats; after release, no stale out_valid is produced.

Decomposition:
- Shared package fp32_pkg: EXP_W, FRAC_W, SUM_W, the binary32 field constants (EXP_MAX=8'hFF, QNAN=32'h7FC00000, ZERO) and the packed-result type.
- One natural sub-module, fp_rne_round: combinational; inputs {frac, G, R, S, E1}; outputs {f, E2}.
- The residual barrel shift stays inline in the stage-1 logic.

Test Plan:
- 1.0+1.0: SumS_5=33'h1_0000_0000, Shift=0, Emax=127, Opr=0 -> Result=32'h40000000, Ovf=0, Unf=0, after 2 cycles.
- Exact cancel 1.0−1.0: SumS_5=0, Shift=26, Emax=127, PSgn=1, Opr=1 -> Result=32'h00000000.
- RNE ties, Shift=0, Emax=127:
  - SumS_5=33'h1_0000_0100 -> 32'h40000000 (tie, L=0, no increment).
  - SumS_5=33'h1_0000_0300 -> 32'h40000002 (tie, L=1, increment).
  - SumS_5=33'h1_FFFF_FF00 -> 32'h40800000 (mantissa carry bumps the exponent).
- Range limits:
  - Emax=254, Shift=0, PSgn=0 -> Result=32'h7F800000, Ovf=1.
  - Emax=3, Shift=5 -> E2=−1 -> Result={PSgn, 31'b0}, Unf=1.
- Backpressure: stream 4 beats with out_ready=0 for cycles 2–5.
  - in_ready falls after 2 beats are accepted.
  - Result stays stable while stalled.
  - All 4 results emerge in order with no loss or duplication.
  - Back-to-back 1/cycle throughput with out_ready=1.
- Reset mid-flight: drop rst_n with 2 beats in flight -> out_valid=0 and Result=0 immediately (asynchronous); no out_valid after release until a new beat is accepted.

Source files
------------

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared widths, binary32 field constants and the packed result
// type for the single-precision add/sub datapath.
package fp32_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int SUM_W   = FRAC_W + 10;  // pre-shifted sum width (33)
  localparam int SHIFT_W = 5;
  localparam int E_W     = EXP_W + 2;    // signed working exponent width

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam logic [31:0]      QNAN    = 32'h7FC0_0000;
  localparam logic [31:0]      ZERO    = 32'h0000_0000;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp_rne_round.sv
// fp_rne_round: combinational round-to-nearest-even of a normalized fraction.
// Ports:
//   frac : stored fraction bits (hidden bit excluded); frac[0] is the L bit
//   g/r/s: guard, round and sticky bits below the fraction
//   e1   : signed exponent before rounding
//   f    : rounded fraction (zero when rounding carries out)
//   e2   : exponent after rounding (e1 + 1 on carry-out)
module fp_rne_round
  import fp32_pkg::*;
(
  input  logic                    [FRAC_W-1:0] frac,
  input  logic                                 g,
  input  logic                                 r,
  input  logic                                 s,
  input  logic signed             [E_W-1:0]    e1,
  output logic                    [FRAC_W-1:0] f,
  output logic signed             [E_W-1:0]    e2
);

  localparam logic signed [E_W-1:0] E_ONE = 1;

  logic              inc;
  logic [FRAC_W:0]   sum;

  // Round up above half, or exactly half when the kept LSB is odd.
  assign inc = g & (r | s | frac[0]);
  assign sum = {1'b0, frac} + {{FRAC_W{1'b0}}, inc};

  // A carry-out only happens when frac was all ones, so the low bits of sum
  // are already zero and the significand becomes 1.0 at the next exponent.
  assign f  = sum[FRAC_W-1:0];
  assign e2 = sum[FRAC_W] ? (e1 + E_ONE) : e1;

endmodule

// File: rtl/fpaddsub_c_32.sv
// fpaddsub_c_32: final normalize / round / pack stage of the binary32
// add/sub datapath, as a 2-stage valid/ready pipeline.
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : input beat handshake
//   SumS_5              : sum after the coarse 16|0 shift (hidden bit at MSB)
//   Shift               : total normalization shift (0..26)
//   Emax                : biased exponent of the larger operand
//   PSgn, Opr           : result sign, effective operation (1 = subtract)
//   out_valid/out_ready : result handshake; outputs hold while stalled
//   Result, Ovf, Unf    : packed binary32 result and range flags
module fpaddsub_c_32 #(
  parameter int EXP_W  = fp32_pkg::EXP_W,
  parameter int FRAC_W = fp32_pkg::FRAC_W,
  parameter int BIAS   = 127
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FRAC_W+9:0]       SumS_5,
  input  logic [4:0]              Shift,
  input  logic [EXP_W-1:0]        Emax,
  input  logic                    PSgn,
  input  logic                    Opr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   Result,
  output logic                    Ovf,
  output logic                    Unf
);

  import fp32_pkg::*;

  // Bits of the normalized sum below the hidden bit: fraction + G/R/S.
  localparam int N_W = FRAC_W + 9;
  localparam logic signed [E_W-1:0] E_OVF  = E_W'(2 * BIAS + 1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;

  // Handshake
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s1_en;
  logic s2_en;

  assign s2_en     = !s2_valid_reg | out_ready;
  assign s1_en     = !s1_valid_reg | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid_reg;

  // Stage 1: residual shift and exponent adjust
  logic                    shift_ok;
  logic [4:0]              shift_eff;
  logic [3:0]              res_sh;
  logic [N_W-1:0]          lvl [0:4];
  logic signed [E_W-1:0]   e1_next;
  logic                    z_next;

  // Out-of-range shift amounts are treated as no shift at all.
  assign shift_ok  = (Shift <= 5'd26);
  assign shift_eff = shift_ok ? Shift : 5'd0;
  assign res_sh    = shift_eff[3:0];

  // The hidden bit (SumS_5 MSB) always lands at or above the fraction window,
  // so only the lower N_W bits need to pass through the barrel.
  assign lvl[0] = SumS_5[N_W-1:0];

  for (genvar gi = 0; gi < 4; gi++) begin : g_barrel
    localparam int AMT = 8 >> gi;
    assign lvl[gi+1] = res_sh[3-gi] ? (lvl[gi] << AMT) : lvl[gi];
  end

  assign e1_next = $signed(E_W'(Emax) + E_W'(1) - E_W'(shift_eff));
  assign z_next  = (Shift == 5'd26) || (SumS_5 == '0);

  logic [N_W-1:0]          n_reg;
  logic signed [E_W-1:0]   e1_reg;
  logic                    z_reg;
  logic                    sgn_reg;
  logic                    opr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      n_reg        <= '0;
      e1_reg       <= '0;
      z_reg        <= 1'b0;
      sgn_reg      <= 1'b0;
      opr_reg      <= 1'b0;
    end else if (s1_en) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        n_reg   <= lvl[4];
        e1_reg  <= e1_next;
        z_reg   <= z_next;
        sgn_reg <= PSgn;
        opr_reg <= Opr;
      end
    end
  end

  // Stage 2: round and pack
  logic [FRAC_W-1:0]       f_rnd;
  logic signed [E_W-1:0]   e2;

  fp_rne_round u_round (
    .frac (n_reg[N_W-1:9]),
    .g    (n_reg[8]),
    .r    (n_reg[7]),
    .s    (|n_reg[6:0]),
    .e1   (e1_reg),
    .f    (f_rnd),
    .e2   (e2)
  );

  fp32_t res_next;
  logic  ovf_next;
  logic  unf_next;

  always_comb begin
    res_next = '{sign: sgn_reg, exp: e2[EXP_W-1:0], frac: f_rnd};
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (z_reg) begin
      // Exact cancellation under subtraction yields +0.
      res_next      = ZERO;
      res_next.sign = opr_reg ? 1'b0 : sgn_reg;
    end else if (e2 >= E_OVF) begin
      res_next = '{sign: sgn_reg, exp: EXP_MAX, frac: '0};
      ovf_next = 1'b1;
    end else if (e2 <= E_ZERO) begin
      // Denormal range is flushed to signed zero.
      res_next      = ZERO;
      res_next.sign = sgn_reg;
      unf_next      = 1'b1;
    end
  end

  fp32_t result_reg;
  logic  ovf_reg;
  logic  unf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      result_reg   <= ZERO;
      ovf_reg      <= 1'b0;
      unf_reg      <= 1'b0;
    end else if (s2_en) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        result_reg <= res_next;
        ovf_reg    <= ovf_next;
        unf_reg    <= unf_next;
      end
    end
  end

  assign Result = result_reg;
  assign Ovf    = ovf_reg;
  assign Unf    = unf_reg;

endmodule

// File: tb/tb_fpaddsub_c_32.sv
// tb_fpaddsub_c_32: self-checking bench for the normalize/round/pack stage.
// Expected results come from an arithmetic reference model (integer division
// for rounding, plain exponent arithmetic for range limits) and a FIFO
// scoreboard for ordering under backpressure.
module tb_fpaddsub_c_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [32:0] sum_s5;
  logic [4:0]  shift;
  logic [7:0]  emax;
  logic        psgn;
  logic        opr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        unf;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        unf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fpaddsub_c_32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SumS_5    (sum_s5),
    .Shift     (shift),
    .Emax      (emax),
    .PSgn      (psgn),
    .Opr       (opr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (result),
    .Ovf       (ovf),
    .Unf       (unf)
  );

  // Reference: the value below the hidden bit is (SumS_5 * 2^sh) mod 2^32;
  // its top 23 bits form the fraction, the 9 below are rounded away.
  function automatic exp_t ref_model(input logic [32:0] s, input logic [4:0] sh,
                                     input logic [7:0] em, input logic sg, input logic op);
    exp_t   x;
    longint t, q, rem;
    int     shv, e;
    shv   = (sh > 5'd26) ? 0 : int'(sh);
    x.ovf = 1'b0;
    x.unf = 1'b0;
    if (sh == 5'd26 || s == 33'd0) begin
      x.res = {(op ? 1'b0 : sg), 31'd0};
      return x;
    end
    t   = (longint'(s) << (shv % 16)) % 64'h1_0000_0000;
    q   = t / 512;
    rem = t % 512;
    e   = int'(em) + 1 - shv;
    if (rem > 256 || (rem == 256 && (q % 2) == 1)) q = q + 1;
    if (q == 64'd8388608) begin
      q = 0;
      e = e + 1;
    end
    if (e >= 255) begin
      x.res = {sg, 8'hFF, 23'd0};
      x.ovf = 1'b1;
    end else if (e <= 0) begin
      x.res = {sg, 31'd0};
      x.unf = 1'b1;
    end else begin
      x.res = {sg, e[7:0], q[22:0]};
    end
    return x;
  endfunction

  task automatic drive_beat(input logic [32:0] s, input logic [4:0] sh,
                            input logic [7:0] em, input logic sg, input logic op);
    in_valid = 1'b1;
    sum_s5   = s;
    shift    = sh;
    emax     = em;
    psgn     = sg;
    opr      = op;
  endtask

  task automatic rand_beat(output logic [32:0] s, output logic [4:0] sh,
                           output logic [7:0] em, output logic sg, output logic op);
    s = {1'($urandom_range(0, 1)), 32'($urandom())};
    if ($urandom_range(0, 3) == 0) s[8:0] = 9'h100;
    if ($urandom_range(0, 19) == 0) s = '0;
    sh = 5'($urandom_range(0, 26));
    em = 8'($urandom_range(0, 255));
    sg = 1'($urandom_range(0, 1));
    op = 1'($urandom_range(0, 1));
  endtask

  // Sends one beat into an idle pipeline and waits (bounded) for its result.
  task automatic send_one(input logic [32:0] s, input logic [4:0] sh, input logic [7:0] em,
                          input logic sg, input logic op,
                          output logic [31:0] r, output logic o, output logic u, output int lat);
    @(posedge clk); #1;
    out_ready = 1'b1;
    drive_beat(s, sh, em, sg, op);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    r = result;
    o = ovf;
    u = unf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sum_s5 = '0; shift = '0; emax = '0; psgn = 1'b0; opr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL reset_result: got %h want 00000000", result); end
    n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_cmp++; if (unf !== 1'b0) begin n_bad++; $display("FAIL reset_unf: got %b want 0", unf); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    $display("reset: out_valid=%b result=%h in_ready=%b", out_valid, result, in_ready);
  endtask

  task automatic test_basic();
    logic [31:0] r; logic o, u; int lat;
    send_one(33'h1_0000_0000, 5'd0, 8'd127, 1'b0, 1'b0, r, o, u, lat);
    $display("basic 1.0+1.0: result=%h ovf=%b unf=%b latency=%0d", r, o, u, lat);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL basic_latency: got %0d want 2", lat); end
    n_cmp++; if (r !== 32'h4000_0000) begin n_bad++; $display("FAIL basic_result: got %h want 40000000", r); end
    n_cmp++; if (o !== 1'b0 || u !== 1'b0) begin n_bad++; $display("FAIL basic_flags: got ovf=%b unf=%b want 0/0", o, u); end
  endtask

  task automatic test_zero();
    logic [32:0] ts [3] = '{33'h0, 33'h0, 33'h1_2345_6789};
    logic [4:0]  th [3] = '{5'd26, 5'd3, 5'd26};
    logic        tg [3] = '{1'b1, 1'b1, 1'b1};
    logic        tp [3] = '{1'b1, 1'b0, 1'b0};
    logic [31:0] te [3] = '{32'h0000_0000, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] r; logic o, u; int lat;
    for (int i = 0; i < 3; i++) begin
      send_one(ts[i], th[i], 8'd127, tg[i], tp[i], r, o, u, lat);
      $display("zero[%0d]: result=%h ovf=%b unf=%b", i, r, o, u);
      n_cmp++;
      if (r !== te[i] || o !== 1'b0 || u !== 1'b0)
        begin n_bad++; $display("FAIL zero[%0d]: got %h ovf=%b unf=%b want %h ovf=0 unf=0", i, r, o, u, te[i]); end
    end
  endtask

  task automatic test_rne();
    logic [32:0] ts [3] = '{33'h1_0000_0100, 33'h1_0000_0300, 33'h1_FFFF_FF00};
    logic [31:0] te [3] = '{32'h4000_0000, 32'h4000_0002, 32'h4080_0000};
    logic [31:0] r; logic o, u; int lat;
    for (int i = 0; i < 3; i++) begin
      send_one(ts[i], 5'd0, 8'd127, 1'b0, 1'b0, r, o, u, lat);
      $display("rne[%0d]: sum=%h result=%h", i, ts[i], r);
      n_cmp++;
      if (r !== te[i] || o !== 1'b0 || u !== 1'b0)
        begin n_bad++; $display("FAIL rne[%0d]: got %h ovf=%b unf=%b want %h ovf=0 unf=0", i, r, o, u, te[i]); end
    end
  endtask

  task automatic test_range();
    logic [7:0]  tm [3] = '{8'd254, 8'd3, 8'd255};
    logic [4:0]  th [3] = '{5'd0, 5'd5, 5'd0};
    logic        tg [3] = '{1'b0, 1'b1, 1'b1};
    logic [31:0] te [3] = '{32'h7F80_0000, 32'h8000_0000, 32'hFF80_0000};
    logic        to [3] = '{1'b1, 1'b0, 1'b1};
    logic        tu [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] r; logic o, u; int lat;
    for (int i = 0; i < 3; i++) begin
      send_one(33'h1_0000_0000, th[i], tm[i], tg[i], 1'b0, r, o, u, lat);
      $display("range[%0d]: emax=%0d shift=%0d result=%h ovf=%b unf=%b", i, tm[i], th[i], r, o, u);
      n_cmp++;
      if (r !== te[i] || o !== to[i] || u !== tu[i])
        begin n_bad++; $display("FAIL range[%0d]: got %h ovf=%b unf=%b want %h ovf=%b unf=%b", i, r, o, u, te[i], to[i], tu[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] vs [4]; logic [4:0] vh [4]; logic [7:0] vm [4]; logic vg [4]; logic vp [4];
    int idx = 0; int got = 0; exp_t x; logic [31:0] held;
    for (int i = 0; i < 4; i++) begin
      rand_beat(vs[i], vh[i], vm[i], vg[i], vp[i]);
      vm[i] = 8'($urandom_range(40, 200));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_beat(vs[0], vh[0], vm[0], vg[0], vp[0]);
    repeat (6) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        sb.push_back(ref_model(vs[idx], vh[idx], vm[idx], vg[idx], vp[idx]));
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) drive_beat(vs[idx], vh[idx], vm[idx], vg[idx], vp[idx]);
      else in_valid = 1'b0;
    end
    @(negedge clk);
    $display("backpressure: accepted=%0d in_ready=%b out_valid=%b", idx, in_ready, out_valid);
    n_cmp++; if (idx !== 2) begin n_bad++; $display("FAIL bp_accepted: got %0d want 2", idx); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    held = result;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || result !== held)
        begin n_bad++; $display("FAIL bp_hold: got valid=%b result=%h want valid=1 result=%h", out_valid, result, held); end
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        x = (sb.size() > 0) ? sb.pop_front() : '{32'hxxxx_xxxx, 1'bx, 1'bx};
        $display("bp out[%0d]: result=%h ovf=%b unf=%b", got, result, ovf, unf);
        n_cmp++;
        if (result !== x.res || ovf !== x.ovf || unf !== x.unf)
          begin n_bad++; $display("FAIL bp_out[%0d]: got %h ovf=%b unf=%b want %h ovf=%b unf=%b", got, result, ovf, unf, x.res, x.ovf, x.unf); end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_model(vs[idx], vh[idx], vm[idx], vg[idx], vp[idx]));
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 4) drive_beat(vs[idx], vh[idx], vm[idx], vg[idx], vp[idx]);
      else in_valid = 1'b0;
    end
    n_cmp++; if (got !== 4 || sb.size() !== 0) begin n_bad++; $display("FAIL bp_count: got %0d results (%0d pending) want 4 (0)", got, sb.size()); end
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_duplicate: got out_valid=%b want 0", out_valid); end
    end
    sb.delete();
  endtask

  task automatic test_back_to_back();
    logic [32:0] s; logic [4:0] sh; logic [7:0] em; logic sg, op;
    int sent = 0; int got = 0; int cyc = 0; int stall = 0; exp_t x;
    @(posedge clk); #1;
    out_ready = 1'b1;
    rand_beat(s, sh, em, sg, op);
    drive_beat(s, sh, em, sg, op);
    while (got < 20 && cyc < 60) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        x = (sb.size() > 0) ? sb.pop_front() : '{32'hxxxx_xxxx, 1'bx, 1'bx};
        $display("b2b out[%0d]: result=%h ovf=%b unf=%b", got, result, ovf, unf);
        n_cmp++;
        if (result !== x.res || ovf !== x.ovf || unf !== x.unf)
          begin n_bad++; $display("FAIL b2b_out[%0d]: got %h ovf=%b unf=%b want %h ovf=%b unf=%b", got, result, ovf, unf, x.res, x.ovf, x.unf); end
        got++;
      end
      if (in_valid) begin
        if (!in_ready) stall++;
        else begin
          sb.push_back(ref_model(s, sh, em, sg, op));
          sent++;
        end
      end
      cyc++;
      @(posedge clk); #1;
      if (sent < 20) begin
        rand_beat(s, sh, em, sg, op);
        drive_beat(s, sh, em, sg, op);
      end else in_valid = 1'b0;
    end
    n_cmp++; if (cyc !== 22) begin n_bad++; $display("FAIL b2b_cycles: got %0d want 22", cyc); end
    n_cmp++; if (stall !== 0) begin n_bad++; $display("FAIL b2b_stalls: got %0d want 0", stall); end
    sb.delete();
  endtask

  task automatic test_random();
    logic [32:0] s; logic [4:0] sh; logic [7:0] em; logic sg, op;
    int got = 0; int sent = 0; exp_t x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (c < 300) begin
        rand_beat(s, sh, em, sg, op);
        drive_beat(s, sh, em, sg, op);
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < 6);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (out_valid && out_ready) begin
        x = (sb.size() > 0) ? sb.pop_front() : '{32'hxxxx_xxxx, 1'bx, 1'bx};
        $display("rand out[%0d]: result=%h ovf=%b unf=%b", got, result, ovf, unf);
        n_cmp++;
        if (result !== x.res || ovf !== x.ovf || unf !== x.unf)
          begin n_bad++; $display("FAIL rand_out[%0d]: got %h ovf=%b unf=%b want %h ovf=%b unf=%b", got, result, ovf, unf, x.res, x.ovf, x.unf); end
        got++;
      end
      if (in_valid && in_ready) begin
        sb.push_back(ref_model(s, sh, em, sg, op));
        sent++;
      end
      @(posedge clk); #1;
      if (c >= 300 && sb.size() == 0) break;
    end
    in_valid = 1'b0;
    n_cmp++; if (got !== sent) begin n_bad++; $display("FAIL rand_count: got %0d results want %0d", got, sent); end
    sb.delete();
  endtask

  task automatic test_reset_midflight();
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive_beat(33'h1_0000_0000, 5'd0, 8'd127, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive_beat(33'h1_0000_0300, 5'd0, 8'd127, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b1 || result !== 32'h4000_0000)
      begin n_bad++; $display("FAIL midrst_before: got valid=%b result=%h want valid=1 result=40000000", out_valid, result); end
    #1 rst_n = 1'b0;
    #1;
    $display("midflight reset: out_valid=%b result=%h", out_valid, result);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (result !== 32'h0) begin n_bad++; $display("FAIL midrst_result: got %h want 00000000", result); end
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_stale: got out_valid=%b want 0", out_valid); end
    end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_rne();
    test_range();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
